// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, FSM states, payload type.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_word_t;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register that catches a fetched word while decode is stalled.
module fetch_skid_buffer
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic            drain,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  fetch_word_t entry;

  // Clear wins over load; load and drain never coincide because a full entry blocks new fetches.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      entry <= '{instr: NOP_INSTR, pc: '0};
    end else if (load) begin
      valid <= 1'b1;
      entry <= '{instr: in_instr, pc: in_pc};
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  assign instr = entry.instr;
  assign pc    = entry.pc;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues one outstanding imem fetch at a time and fills the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        ID_valid_o,
  output logic [31:0] ID_instr_o,
  output logic [31:0] ID_pc_o
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, resp_pc;
  logic            req, handshake, deliver;
  logic            skid_valid;
  logic [XLEN-1:0] skid_instr, skid_pc;
  logic            id_valid;
  logic [XLEN-1:0] id_instr, id_pc;

  // Fetch FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_REQ;
    else       state <= state_next;
  end

  // Next state and request generation; a flush always suppresses the request for that cycle.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    case (state)
      S_REQ: begin
        req = !flush_i && !skid_valid;
        if (req && imem_gnt_i) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (flush_i) begin
          state_next = imem_rvalid_i ? S_REQ : S_KILL;
        end else if (imem_rvalid_i) begin
          req        = !stall_i && !skid_valid;
          state_next = (req && imem_gnt_i) ? S_WAIT : S_REQ;
        end
      end
      S_KILL: begin
        // The squashed response is the only one outstanding; once it lands we are free to refetch.
        if (imem_rvalid_i) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
    if (rst_i) req = 1'b0;
  end

  assign handshake   = req && imem_gnt_i;
  assign deliver     = (state == S_WAIT) && imem_rvalid_i && !flush_i;
  assign imem_req_o  = req;
  assign imem_addr_o = pc;

  // PC and outstanding-fetch PC; redirect takes effect immediately, handshake advances sequentially.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc      <= RESET_PC;
      resp_pc <= '0;
    end else if (flush_i) begin
      pc <= word_align(branch_addr_i);
    end else if (handshake) begin
      resp_pc <= pc;
      pc      <= pc + PC_STEP;
    end
  end

  fetch_skid_buffer u_skid (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (flush_i),
    .load     (deliver && stall_i),
    .drain    (!stall_i && skid_valid),
    .in_instr (imem_rdata_i),
    .in_pc    (resp_pc),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  // IF/ID register: flush squashes, stall holds, otherwise take fresh word, then skid, else bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
    end else if (flush_i) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end else if (!stall_i) begin
      if (deliver) begin
        id_valid <= 1'b1;
        id_instr <= imem_rdata_i;
        id_pc    <= resp_pc;
      end else if (skid_valid) begin
        id_valid <= 1'b1;
        id_instr <= skid_instr;
        id_pc    <= skid_pc;
      end else begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end
    end
  end

  assign ID_valid_o = id_valid;
  assign ID_instr_o = id_instr;
  assign ID_pc_o    = id_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: throughput, grant wait, stall/skid, flush cases, wrap and reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst, stall, flush, gnt;
  logic [31:0] branch;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        id_valid;
  logic [31:0] id_instr, id_pc;

  int n_chk;
  int n_fail;

  // Memory model: data word is the bitwise inverse of its address; latency chosen per grant.
  int          mem_lat;
  int          mem_cnt;
  logic        mem_pend;
  logic [31:0] mem_addr;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .flush_i       (flush),
    .branch_addr_i (branch),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .ID_valid_o    (id_valid),
    .ID_instr_o    (id_instr),
    .ID_pc_o       (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One response per grant, after mem_lat cycles; reset drops anything in flight.
  always @(posedge clk) begin
    if (rst) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
    end else begin
      if (rvalid) mem_pend <= 1'b0;
      else if (mem_pend && mem_cnt > 0) mem_cnt <= mem_cnt - 1;
      if (imem_req && gnt) begin
        mem_pend <= 1'b1;
        mem_addr <= imem_addr;
        mem_cnt  <= mem_lat - 1;
      end
    end
  end

  assign rvalid = mem_pend && (mem_cnt == 0);
  assign rdata  = ~mem_addr;

  // Reset for two cycles; returns just after the negedge of cycle 0 (first cycle out of reset).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; flush = 1'b0; gnt = 1'b1; branch = 32'h0; mem_lat = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; flush = 1'b0; gnt = 1'b1; branch = 32'h0; mem_lat = 1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", id_valid); end
    n_chk++; if (id_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_instr: got %h expected 00000013", id_instr); end
    n_chk++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h expected 00000000", id_pc); end
    @(negedge clk); rst = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_first_req: got %b expected 1", imem_req); end
    n_chk++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rst_first_addr: got %h expected 00000100", imem_addr); end
  endtask

  task automatic test_throughput();
    do_reset();
    n_chk++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL thr_addr0: got %h expected 00000100", imem_addr); end
    @(negedge clk); #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin n_fail++; $display("FAIL thr_addr1: got req=%b addr=%h expected req=1 addr=00000104", imem_req, imem_addr); end
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL thr_valid1: got %b expected 0", id_valid); end
    @(negedge clk); #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin n_fail++; $display("FAIL thr_addr2: got req=%b addr=%h expected req=1 addr=00000108", imem_req, imem_addr); end
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin n_fail++; $display("FAIL thr_id2: got v=%b pc=%h expected v=1 pc=00000100", id_valid, id_pc); end
    n_chk++; if (id_instr !== 32'hFFFF_FEFF) begin n_fail++; $display("FAIL thr_instr2: got %h expected fffffeff", id_instr); end
    @(negedge clk); #1;
    n_chk++; if (imem_addr !== 32'h10C) begin n_fail++; $display("FAIL thr_addr3: got %h expected 0000010c", imem_addr); end
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h104) begin n_fail++; $display("FAIL thr_id3: got v=%b pc=%h expected v=1 pc=00000104", id_valid, id_pc); end
    @(negedge clk); #1;
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h108) begin n_fail++; $display("FAIL thr_id4: got v=%b pc=%h expected v=1 pc=00000108", id_valid, id_pc); end
  endtask

  task automatic test_grant_wait();
    do_reset();
    gnt = 1'b0;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL gw_c0: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL gw_c1: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
    @(negedge clk); gnt = 1'b1; #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL gw_c2: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_chk++; if (imem_addr !== 32'h104 || id_valid !== 1'b0) begin n_fail++; $display("FAIL gw_c3: got addr=%h v=%b expected addr=00000104 v=0", imem_addr, id_valid); end
    @(negedge clk); #1;
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin n_fail++; $display("FAIL gw_c4: got v=%b pc=%h expected v=1 pc=00000100", id_valid, id_pc); end
  endtask

  task automatic test_stall_skid();
    do_reset();
    @(negedge clk); #1;
    @(negedge clk); stall = 1'b1; #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stl_req2: got %b expected 0", imem_req); end
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin n_fail++; $display("FAIL stl_id2: got v=%b pc=%h expected v=1 pc=00000100", id_valid, id_pc); end
    for (int c = 3; c <= 4; c++) begin
      @(negedge clk); #1;
      n_chk++; if (imem_req !== 1'b0 || id_pc !== 32'h100 || id_valid !== 1'b1) begin n_fail++; $display("FAIL stl_hold c%0d: got req=%b v=%b pc=%h expected req=0 v=1 pc=00000100", c, imem_req, id_valid, id_pc); end
    end
    @(negedge clk); stall = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b0 || id_pc !== 32'h100) begin n_fail++; $display("FAIL stl_rel5: got req=%b pc=%h expected req=0 pc=00000100", imem_req, id_pc); end
    @(negedge clk); #1;
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h104 || id_instr !== 32'hFFFF_FEFB) begin n_fail++; $display("FAIL stl_drain6: got v=%b pc=%h instr=%h expected v=1 pc=00000104 instr=fffffefb", id_valid, id_pc, id_instr); end
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin n_fail++; $display("FAIL stl_req6: got req=%b addr=%h expected req=1 addr=00000108", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL stl_bubble7: got %b expected 0", id_valid); end
    @(negedge clk); #1;
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h108) begin n_fail++; $display("FAIL stl_id8: got v=%b pc=%h expected v=1 pc=00000108", id_valid, id_pc); end
  endtask

  task automatic test_flush_outstanding();
    do_reset();
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); mem_lat = 3; #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin n_fail++; $display("FAIL flo_req3: got req=%b addr=%h expected req=1 addr=0000010c", imem_req, imem_addr); end
    @(negedge clk); flush = 1'b1; branch = 32'h2002; #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flo_req4: got %b expected 0", imem_req); end
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h108) begin n_fail++; $display("FAIL flo_id4: got v=%b pc=%h expected v=1 pc=00000108", id_valid, id_pc); end
    @(negedge clk); flush = 1'b0; mem_lat = 1; #1;
    n_chk++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL flo_c5: got v=%b req=%b expected v=0 req=0", id_valid, imem_req); end
    @(negedge clk); #1;
    n_chk++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL flo_kill6: got req=%b v=%b instr=%h expected req=0 v=0 instr=00000013", imem_req, id_valid, id_instr); end
    @(negedge clk); #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin n_fail++; $display("FAIL flo_req7: got req=%b addr=%h expected req=1 addr=00002000", imem_req, imem_addr); end
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flo_drop7: got %b expected 0", id_valid); end
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h2000 || id_instr !== 32'hFFFF_DFFF) begin n_fail++; $display("FAIL flo_id9: got v=%b pc=%h instr=%h expected v=1 pc=00002000 instr=ffffdfff", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_flush_stall_rvalid();
    do_reset();
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); flush = 1'b1; stall = 1'b1; branch = 32'h2000; #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL fsr_req3: got %b expected 0", imem_req); end
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h104) begin n_fail++; $display("FAIL fsr_id3: got v=%b pc=%h expected v=1 pc=00000104", id_valid, id_pc); end
    @(negedge clk); flush = 1'b0; stall = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin n_fail++; $display("FAIL fsr_req4: got req=%b addr=%h expected req=1 addr=00002000", imem_req, imem_addr); end
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL fsr_v4: got %b expected 0", id_valid); end
    @(negedge clk); #1;
    n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL fsr_skid5: got %b expected 0", id_valid); end
    @(negedge clk); #1;
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h2000) begin n_fail++; $display("FAIL fsr_id6: got v=%b pc=%h expected v=1 pc=00002000", id_valid, id_pc); end
  endtask

  task automatic test_double_flush();
    do_reset();
    mem_lat = 4;
    @(negedge clk); flush = 1'b1; branch = 32'h300; #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL dfl_req1: got %b expected 0", imem_req); end
    @(negedge clk); branch = 32'h400; #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL dfl_req2: got %b expected 0", imem_req); end
    @(negedge clk); flush = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL dfl_req3: got %b expected 0", imem_req); end
    @(negedge clk); mem_lat = 1; #1;
    n_chk++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL dfl_kill4: got req=%b v=%b expected req=0 v=0", imem_req, id_valid); end
    @(negedge clk); #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin n_fail++; $display("FAIL dfl_req5: got req=%b addr=%h expected req=1 addr=00000400", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_chk++; if (imem_addr !== 32'h404 || id_valid !== 1'b0) begin n_fail++; $display("FAIL dfl_c6: got addr=%h v=%b expected addr=00000404 v=0", imem_addr, id_valid); end
    @(negedge clk); #1;
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h400 || id_instr !== 32'hFFFF_FBFF) begin n_fail++; $display("FAIL dfl_id7: got v=%b pc=%h instr=%h expected v=1 pc=00000400 instr=fffffbff", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    flush = 1'b1; branch = 32'hFFFF_FFFF; #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wrp_req0: got %b expected 0", imem_req); end
    @(negedge clk); flush = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrp_req1: got req=%b addr=%h expected req=1 addr=fffffffc", imem_req, imem_addr); end
    @(negedge clk); mem_lat = 4; #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrp_req2: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_instr !== 32'h0000_0003) begin n_fail++; $display("FAIL wrp_id3: got v=%b pc=%h instr=%h expected v=1 pc=fffffffc instr=00000003", id_valid, id_pc, id_instr); end
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wrp_wait3: got %b expected 0", imem_req); end
    @(negedge clk); rst = 1'b1; #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mrs_req4: got %b expected 0", imem_req); end
    @(negedge clk); #1;
    n_chk++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL mrs_c5: got req=%b v=%b expected req=0 v=0", imem_req, id_valid); end
    @(negedge clk); rst = 1'b0; mem_lat = 1; #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL mrs_req6: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin n_fail++; $display("FAIL mrs_id8: got v=%b pc=%h expected v=1 pc=00000100", id_valid, id_pc); end
  endtask

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; gnt = 1'b1; branch = 32'h0; mem_lat = 1;
    test_reset();
    test_throughput();
    test_grant_wait();
    test_stall_skid();
    test_flush_outstanding();
    test_flush_stall_rvalid();
    test_double_flush();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
